// File: rtl/upower_mc_sequencer_if.sv
// Control bundle between the uPOWER multi-cycle sequencer and its datapath.
// The master side is the sequencer: it observes instruction fields, memory
// acknowledgements and the ALU branch flag, and drives the datapath enables.
interface upower_mc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       opcode;
  logic [9:0]       xo;
  logic             alu_branch;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             ir_load;
  logic             alu_en;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_we;
  logic             mem_to_reg;
  logic             pc_write;
  logic             pc_src;
  logic             busy;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, opcode, xo, alu_branch, imem_ack, dmem_ack,
    output imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_we,
           mem_to_reg, pc_write, pc_src, busy, illegal, retired
  );

  modport slave (
    output run, opcode, xo, alu_branch, imem_ack, dmem_ack,
    input  imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_we,
           mem_to_reg, pc_write, pc_src, busy, illegal, retired
  );
endinterface

// File: rtl/upower_mc_sequencer.sv
// uPOWER multi-cycle control sequencer: steps each instruction through
// FETCH / DECODE / EXEC / MEM / WB around a shared ALU, with req/ack memory
// handshakes and a terminal TRAP state for unsupported instructions.
module upower_mc_sequencer #(
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  upower_mc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // Instruction class latched in DECODE; conditional and unconditional
  // branches are kept apart so EXEC knows whether to consult alu_branch.
  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_STU, C_BRU, C_BRC, C_ILL
  } cls_t;

  // Registered Moore outputs. br_cond marks the EXEC cycle of a conditional
  // branch, where pc_src follows the ALU flag of that same cycle.
  typedef struct packed {
    logic imem_req;
    logic alu_en;
    logic dmem_req;
    logic dmem_we;
    logic reg_we;
    logic mem_to_reg;
    logic pc_write;
    logic pc_src;
    logic br_cond;
    logic busy;
    logic illegal;
  } outs_t;

  function automatic cls_t f_decode(input logic [5:0] op, input logic [9:0] x);
    cls_t c;
    case (op)
      6'd31: begin
        case (x)
          10'd266, 10'd40, 10'd28, 10'd986,
          10'd476, 10'd444, 10'd316:       c = C_ALU;
          default:                          c = C_ILL;
        endcase
      end
      6'd14, 6'd15, 6'd28, 6'd24, 6'd26:   c = C_ALU;
      6'd32, 6'd34, 6'd40, 6'd42, 6'd58:   c = C_LOAD;
      6'd36, 6'd38, 6'd44, 6'd62:          c = C_STORE;
      6'd37:                               c = C_STU;
      6'd18:                               c = C_BRU;
      6'd19:                               c = C_BRC;
      default:                             c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic outs_t f_outs(input state_t s, input cls_t c);
    outs_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.imem_req = 1'b1;
        o.busy     = 1'b1;
      end
      S_DECODE: begin
        o.busy = 1'b1;
      end
      S_EXEC: begin
        o.alu_en = 1'b1;
        o.busy   = 1'b1;
        if (c == C_BRU) begin
          o.pc_write = 1'b1;
          o.pc_src   = 1'b1;
        end
        if (c == C_BRC) begin
          o.pc_write = 1'b1;
          o.br_cond  = 1'b1;
        end
      end
      S_MEM: begin
        o.dmem_req = 1'b1;
        o.dmem_we  = (c == C_STORE) || (c == C_STU);
        o.busy     = 1'b1;
      end
      S_WB: begin
        o.reg_we     = 1'b1;
        o.pc_write   = 1'b1;
        o.mem_to_reg = (c == C_LOAD);
        o.busy       = 1'b1;
      end
      S_TRAP: begin
        o.illegal = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t           r_state;
  cls_t             r_cls;
  outs_t            r_out;
  logic [CNT_W-1:0] r_retired;

  cls_t             w_dec_cls;
  cls_t             w_cls_nxt;
  state_t           w_state_nxt;
  state_t           w_run_nxt;
  logic             w_st_done;
  logic             w_retire;

  assign w_dec_cls = f_decode(bus.opcode, bus.xo);

  // A plain store finishes on its data ack, so its PC update rides on the ack.
  assign w_st_done = r_out.dmem_req && (r_cls == C_STORE) && bus.dmem_ack;

  // Next-state and class selection; the class is captured only in DECODE.
  always_comb begin
    w_cls_nxt   = r_cls;
    w_run_nxt   = bus.run ? S_FETCH : S_IDLE;
    w_state_nxt = r_state;
    if (r_state == S_DECODE) begin
      w_cls_nxt = w_dec_cls;
    end
    case (r_state)
      S_IDLE:   if (bus.run) w_state_nxt = S_FETCH;
      S_FETCH:  if (bus.imem_ack) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = (w_dec_cls == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (r_cls)
          C_ALU:                  w_state_nxt = S_WB;
          C_LOAD, C_STORE, C_STU: w_state_nxt = S_MEM;
          C_BRU, C_BRC:           w_state_nxt = w_run_nxt;
          default:                w_state_nxt = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          w_state_nxt = (r_cls == C_STORE) ? w_run_nxt : S_WB;
        end
      end
      S_WB:     w_state_nxt = w_run_nxt;
      S_TRAP:   w_state_nxt = S_TRAP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Retire in WB, in EXEC of a branch, or on the data ack of a plain store.
  always_comb begin
    w_retire = 1'b0;
    if (r_state == S_WB) begin
      w_retire = 1'b1;
    end
    if ((r_state == S_EXEC) && ((r_cls == C_BRU) || (r_cls == C_BRC))) begin
      w_retire = 1'b1;
    end
    if (w_st_done) begin
      w_retire = 1'b1;
    end
  end

  // Sequencer state, latched class and registered outputs for the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cls   <= C_ALU;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cls   <= w_cls_nxt;
      r_out   <= f_outs(w_state_nxt, w_cls_nxt);
    end
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.imem_req   = r_out.imem_req;
  assign bus.ir_load    = r_out.imem_req & bus.imem_ack;
  assign bus.alu_en     = r_out.alu_en;
  assign bus.dmem_req   = r_out.dmem_req;
  assign bus.dmem_we    = r_out.dmem_we;
  assign bus.reg_we     = r_out.reg_we;
  assign bus.mem_to_reg = r_out.mem_to_reg;
  assign bus.pc_write   = r_out.pc_write | w_st_done;
  assign bus.pc_src     = r_out.pc_src | (r_out.br_cond & bus.alu_branch);
  assign bus.busy       = r_out.busy;
  assign bus.illegal    = r_out.illegal;
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_upower_mc_sequencer.sv
// Bench for upower_mc_sequencer: a per-instruction schedule model derived from
// the phase rules (fetch waits, decode, exec, memory waits, write-back) drives
// inputs and predicts every output each cycle; literal checks pin latencies.
module tb_upower_mc_sequencer;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  upower_mc_sequencer_if #(.CNT_W(CW)) bus();
  upower_mc_sequencer #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic imem_req, ir_load, alu_en, dmem_req, dmem_we, reg_we;
    logic mem_to_reg, pc_write, pc_src, busy, illegal;
  } exp_t;

  typedef enum {K_ALU, K_LD, K_ST, K_STU, K_BR, K_ILL} kind_e;

  int tests = 0;
  int fails = 0;
  bit [31:0] m_ret = 0;
  int cyc = 0;
  int ret_seen = 0;

  bit [9:0] alu_xo [7] = '{10'd266, 10'd40, 10'd28, 10'd986, 10'd476, 10'd444, 10'd316};
  bit [5:0] imm_op [5] = '{6'd14, 6'd15, 6'd28, 6'd24, 6'd26};
  bit [5:0] ld_op  [5] = '{6'd32, 6'd34, 6'd40, 6'd42, 6'd58};
  bit [5:0] st_op  [4] = '{6'd36, 6'd38, 6'd44, 6'd62};

  function automatic kind_e classify(input bit [5:0] op, input bit [9:0] x);
    if (op == 6'd31) return (x inside {266, 40, 28, 986, 476, 444, 316}) ? K_ALU : K_ILL;
    if (op inside {14, 15, 28, 24, 26}) return K_ALU;
    if (op inside {32, 34, 40, 42, 58}) return K_LD;
    if (op inside {36, 38, 44, 62}) return K_ST;
    if (op == 6'd37) return K_STU;
    if (op inside {18, 19}) return K_BR;
    return K_ILL;
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a = {bus.imem_req, bus.ir_load, bus.alu_en, bus.dmem_req, bus.dmem_we, bus.reg_we,
         bus.mem_to_reg, bus.pc_write, bus.pc_src, bus.busy, bus.illegal};
    return a;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare 1ns later, move on.
  task automatic step(input bit rv, input bit iack, input bit dack, input bit abr,
                      input exp_t e, input string nm);
    bus.run = rv;
    bus.imem_ack = iack;
    bus.dmem_ack = dack;
    bus.alu_branch = abr;
    #1;
    check({nm, " outs"}, {21'd0, actual()}, {21'd0, e});
    check({nm, " retired"}, 32'(bus.retired), 32'(m_ret[CW-1:0]));
    cyc++;
    if (bus.pc_write === 1'b1 && ret_seen == 0) ret_seen = cyc;
    @(negedge clk);
  endtask

  // Entered with the FSM already in FETCH. rc = cycle (1-based) of retire.
  task automatic run_instr(input bit [5:0] op, input bit [9:0] x, input int wi, input int wd,
                           input bit abr, input bit run_end, output int rc);
    kind_e k;
    exp_t e;
    bit rm;
    k = classify(op, x);
    bus.opcode = op;
    bus.xo = x;
    cyc = 0;
    ret_seen = 0;
    rc = 0;
    for (int i = 0; i < wi; i++) begin
      e = '0; e.imem_req = 1; e.busy = 1;
      step(rnd(), 1'b0, rnd(), rnd(), e, "fetch-wait");
    end
    e = '0; e.imem_req = 1; e.ir_load = 1; e.busy = 1;
    step(rnd(), 1'b1, rnd(), rnd(), e, "fetch-ack");
    e = '0; e.busy = 1;
    step(rnd(), rnd(), rnd(), rnd(), e, "decode");
    if (k == K_ILL) return;
    e = '0; e.alu_en = 1; e.busy = 1;
    if (k == K_BR) begin
      e.pc_write = 1;
      e.pc_src = (op == 6'd18) ? 1'b1 : abr;
      step(run_end, rnd(), rnd(), abr, e, "exec-br");
      m_ret++;
    end else begin
      rm = run_end ? rnd() : 1'b0;
      step(rm, rnd(), rnd(), rnd(), e, "exec");
      if (k != K_ALU) begin
        e = '0; e.dmem_req = 1; e.dmem_we = (k == K_ST || k == K_STU); e.busy = 1;
        for (int i = 0; i < wd; i++) begin
          rm = run_end ? rnd() : 1'b0;
          step(rm, rnd(), 1'b0, rnd(), e, "mem-wait");
        end
        if (k == K_ST) begin
          e.pc_write = 1;
          step(run_end, rnd(), 1'b1, rnd(), e, "mem-ack-st");
          m_ret++;
        end else begin
          rm = run_end ? rnd() : 1'b0;
          step(rm, rnd(), 1'b1, rnd(), e, "mem-ack");
        end
      end
      if (k != K_ST) begin
        e = '0; e.reg_we = 1; e.pc_write = 1; e.mem_to_reg = (k == K_LD); e.busy = 1;
        step(run_end, rnd(), rnd(), rnd(), e, "wb");
        m_ret++;
      end
    end
    rc = ret_seen;
  endtask

  // From IDLE: a few idle cycles, then raise run so the next cycle is FETCH.
  task automatic go_idle();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) step(1'b0, rnd(), rnd(), rnd(), exp_t'(0), "idle");
    step(1'b1, rnd(), rnd(), rnd(), exp_t'(0), "idle-run");
  endtask

  task automatic trap_check(input int n);
    exp_t e;
    e = '0; e.illegal = 1;
    for (int i = 0; i < n; i++) step(1'b1, rnd(), rnd(), rnd(), e, "trap");
  endtask

  task automatic pick(input bit allow_ill, output bit [5:0] op, output bit [9:0] x);
    int sel;
    sel = allow_ill ? $urandom_range(0, 6) : $urandom_range(0, 5);
    x = 10'($urandom);
    case (sel)
      0: begin op = 6'd31; x = alu_xo[$urandom_range(0, 6)]; end
      1: op = imm_op[$urandom_range(0, 4)];
      2: op = ld_op[$urandom_range(0, 4)];
      3: op = st_op[$urandom_range(0, 3)];
      4: op = 6'd37;
      5: op = ($urandom_range(0, 1) != 0) ? 6'd18 : 6'd19;
      default: begin
        do begin
          op = ($urandom_range(0, 1) != 0) ? 6'd31 : 6'($urandom);
          x = 10'($urandom);
        end while (classify(op, x) != K_ILL);
      end
    endcase
  endtask

  task automatic rand_instrs(input int n, input bit allow_ill, output bit trapped);
    bit [5:0] op;
    bit [9:0] x;
    bit re;
    int rc;
    trapped = 0;
    for (int i = 0; i < n; i++) begin
      pick(allow_ill, op, x);
      re = ($urandom_range(0, 3) != 0);
      run_instr(op, x, $urandom_range(0, 3), $urandom_range(0, 3), rnd(), re, rc);
      if (classify(op, x) == K_ILL) begin
        trapped = 1;
        return;
      end
      if (!re) go_idle();
    end
  endtask

  initial begin
    int rc;
    bit trapped;
    exp_t e;
    bus.run = 0; bus.opcode = 0; bus.xo = 0; bus.alu_branch = 0;
    bus.imem_ack = 0; bus.dmem_ack = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset outs", {21'd0, actual()}, 32'd0);
    check("reset retired", 32'(bus.retired), 32'd0);
    @(negedge clk);
    rst_n = 1;
    step(1'b1, 1'b0, 1'b0, 1'b0, exp_t'(0), "idle-run");
    e = '0; e.imem_req = 1; e.busy = 1;
    step(1'b1, 1'b0, 1'b0, 1'b0, e, "fetch-before-reset");

    // Reset in the middle of a fetch handshake
    #2 rst_n = 0;
    #1;
    check("midfetch reset outs", {21'd0, actual()}, 32'd0);
    check("midfetch reset retired", 32'(bus.retired), 32'd0);
    m_ret = 0;
    @(negedge clk);
    rst_n = 1;
    bus.run = 1;
    @(negedge clk);
    check("imem_req after reset release", 32'(bus.imem_req), 32'd1);

    // Directed instructions with literal latencies
    run_instr(6'd31, 10'd266, 0, 0, 1'b0, 1'b1, rc);
    check("alu latency", rc, 4);
    check("alu retired", 32'(bus.retired), 32'd1);
    run_instr(6'd32, 10'd0, 0, 3, 1'b0, 1'b1, rc);
    check("load 3-wait latency", rc, 8);
    run_instr(6'd36, 10'd0, 0, 0, 1'b0, 1'b1, rc);
    check("store latency", rc, 4);
    run_instr(6'd37, 10'd0, 0, 0, 1'b0, 1'b1, rc);
    check("stu latency", rc, 5);
    run_instr(6'd18, 10'd0, 0, 0, 1'b0, 1'b1, rc);
    check("br18 latency", rc, 3);
    run_instr(6'd19, 10'd0, 0, 0, 1'b0, 1'b1, rc);
    check("br19 latency", rc, 3);
    check("br19 next fetch", 32'(bus.imem_req), 32'd1);
    check("retired after six", 32'(bus.retired), 32'd6);

    // run dropped from EXEC on: instruction completes, then IDLE
    run_instr(6'd14, 10'd0, 1, 0, 1'b0, 1'b0, rc);
    check("run-drop latency", rc, 5);
    check("run-drop busy", 32'(bus.busy), 32'd0);
    go_idle();

    // Nine more retirements wrap the 4-bit counter back to zero
    rand_instrs(9, 1'b0, trapped);
    check("retired wrap", 32'(bus.retired), 32'd0);
    rand_instrs(30, 1'b0, trapped);

    // Illegal instruction traps until reset
    run_instr(6'd31, 10'd0, 0, 0, 1'b0, 1'b1, rc);
    trap_check(6);
    check("trap illegal", 32'(bus.illegal), 32'd1);
    check("trap busy", 32'(bus.busy), 32'd0);
    rst_n = 0;
    #1;
    check("trap reset outs", {21'd0, actual()}, 32'd0);
    m_ret = 0;
    @(negedge clk);
    rst_n = 1;
    step(1'b1, 1'b0, 1'b0, 1'b0, exp_t'(0), "idle-run");

    // Random mix including unsupported encodings
    rand_instrs(40, 1'b1, trapped);
    if (trapped) trap_check(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
